// File: rtl/i2s_rx_param_pkg.sv
// Shared definitions for the parametrised I2S receiver: FSM encodings, channel ids, defaults.
package i2s_rx_param_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_START = 2'd0;
    localparam state_t ST_WAIT_FRAME = 2'd1;
    localparam state_t ST_SHIFT      = 2'd2;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // 100 ms at 27 MHz
    localparam int STARTUP_CYC_DEFAULT = 2_700_000;

    // Bits needed to hold values 0..max_val, at least one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2s_rx_param_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input with one-cycle rise/fall pulses.
module i2s_rx_param_sync_edge_det #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STG-1:0] stages;
    logic                prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
            prev   <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STG-2:0], din};
            prev   <= stages[SYNC_STG-1];
        end
    end

    assign sync = stages[SYNC_STG-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2s_rx_param.sv
// I2S serial-to-parallel receiver in the system clock domain: oversampled inputs, startup
// hold-off, configurable word/slot width, stereo or left-only capture, sticky short-slot flag.
module i2s_rx_param
    import i2s_rx_param_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SLOT_W      = 32,
    parameter int STARTUP_CYC = STARTUP_CYC_DEFAULT,
    parameter int STEREO      = 1,
    parameter int SYNC_STG    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] data_l_o,
    output logic [DATA_W-1:0] data_r_o,
    output logic              data_valid_o,
    output logic              ready_o,
    output logic              short_err_o
);

    localparam int CNT_W = cnt_width(STARTUP_CYC);
    localparam int BIT_W = cnt_width(SLOT_W);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYC);
    localparam logic [BIT_W-1:0] SLOT_MAX   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_LEN   = BIT_W'(DATA_W);

    logic sck_sync, sck_rise, sck_fall;
    logic ws_sync, ws_rise, ws_fall;
    logic sd_sync, sd_rise, sd_fall;

    i2s_rx_param_sync_edge_det #(.SYNC_STG(SYNC_STG)) u_sck_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (sck_i),
        .sync (sck_sync),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    i2s_rx_param_sync_edge_det #(.SYNC_STG(SYNC_STG)) u_ws_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (ws_i),
        .sync (ws_sync),
        .rise (ws_rise),
        .fall (ws_fall)
    );

    // sd needs the same delay as sck/ws so all three stay aligned; its edges are not used.
    i2s_rx_param_sync_edge_det #(.SYNC_STG(SYNC_STG)) u_sd_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (sd_i),
        .sync (sd_sync),
        .rise (sd_rise),
        .fall (sd_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_sync, sck_fall, ws_rise, ws_fall, sd_rise, sd_fall};

    state_t             state;
    logic [CNT_W-1:0]   startup_cnt;
    logic               ws_smp;
    logic               channel;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  hold_l;
    logic [DATA_W-1:0]  slot_word;
    logic               ws_edge;

    assign ws_edge = sck_rise & (ws_sync != ws_smp);

    // Short slots hold their bits right-aligned; move them to the MSBs, zero-filling below.
    always_comb begin
        slot_word = shreg;
        if (bit_cnt < DATA_LEN) begin
            slot_word = shreg << (DATA_LEN - bit_cnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_WAIT_START;
            startup_cnt  <= '0;
            ws_smp       <= 1'b0;
            channel      <= CH_L;
            bit_cnt      <= '0;
            shreg        <= '0;
            hold_l       <= '0;
            data_l_o     <= '0;
            data_r_o     <= '0;
            data_valid_o <= 1'b0;
            ready_o      <= 1'b0;
            short_err_o  <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            if (sck_rise) begin
                ws_smp <= ws_sync;
            end

            case (state)
                ST_WAIT_START: begin
                    if (startup_cnt == START_LAST) begin
                        ready_o <= 1'b1;
                        state   <= ST_WAIT_FRAME;
                    end else begin
                        startup_cnt <= startup_cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_FRAME: begin
                    if (ws_edge && !ws_sync) begin
                        state   <= ST_SHIFT;
                        channel <= CH_L;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (ws_edge) begin
                        if (bit_cnt < DATA_LEN) begin
                            short_err_o <= 1'b1;
                        end
                        if (channel == CH_L) begin
                            hold_l <= slot_word;
                        end
                        if (STEREO != 0 && channel == CH_R) begin
                            data_l_o     <= hold_l;
                            data_r_o     <= slot_word;
                            data_valid_o <= 1'b1;
                        end
                        if (STEREO == 0 && channel == CH_L) begin
                            data_l_o     <= slot_word;
                            data_valid_o <= 1'b1;
                        end
                        channel <= ~channel;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else if (sck_rise) begin
                        if (bit_cnt < DATA_LEN) begin
                            shreg <= (shreg << 1) | DATA_W'(sd_sync);
                        end
                        if (bit_cnt != SLOT_MAX) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                default: state <= ST_WAIT_START;
            endcase
        end
    end

endmodule
